// File: rtl/serial_add_controller_if.sv
// Operand/result handshake bundle for serial_add_controller.
// SERIAL_ADD_SUB_EN adds the 'sub' operation select.
interface serial_add_controller_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] lhs;
  logic [WIDTH-1:0] rhs;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             busy;

  modport slave (
    input  in_valid, lhs, rhs, out_ready,
`ifdef SERIAL_ADD_SUB_EN
    input  sub,
`endif
    output in_ready, out_valid, sum, carry, busy
  );

  modport master (
    output in_valid, lhs, rhs, out_ready,
`ifdef SERIAL_ADD_SUB_EN
    output sub,
`endif
    input  in_ready, out_valid, sum, carry, busy
  );
endinterface

// File: rtl/serial_add_controller.sv
// Bit-serial adder: one full-adder slice (two half adders + OR) run over WIDTH cycles, LSB first.
// Define SERIAL_ADD_SUB_EN to add a 'sub' input selecting lhs-rhs.
module one_bit_half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_add_controller #(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  serial_add_controller_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lhs_sh_q, lhs_sh_d;
  logic [WIDTH-1:0] rhs_sh_q, rhs_sh_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic accept, last, rhs_bit, s0, c0, sum_bit, c1, carry_next, carry_init;
  logic [WIDTH-1:0] acc_shift;

`ifdef SERIAL_ADD_SUB_EN
  logic sub_q, sub_d;
  assign rhs_bit    = rhs_sh_q[0] ^ sub_q;
  assign carry_init = bus.sub;
`else
  assign rhs_bit    = rhs_sh_q[0];
  assign carry_init = 1'b0;
`endif

  one_bit_half_adder u_ha0 (.a(lhs_sh_q[0]), .b(rhs_bit), .s(s0),      .c(c0));
  one_bit_half_adder u_ha1 (.a(s0),          .b(carry_q), .s(sum_bit), .c(c1));
  assign carry_next = c0 | c1;

  assign accept    = (state_q == S_IDLE) && bus.in_valid;
  assign last      = (cnt_q == CW'(WIDTH - 1));
  // New sum bit enters at the MSB; the concat keeps WIDTH=1 legal.
  assign acc_shift = {sum_bit, acc_q} >> 1;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.in_valid) state_d = S_RUN;
      S_RUN:   if (last)         state_d = S_DONE;
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.busy      = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      S_IDLE:  bus.in_ready  = 1'b1;
      S_RUN:   bus.busy      = 1'b1;
      S_DONE:  bus.out_valid = 1'b1;
      default: ;
    endcase
  end
  assign bus.sum   = sum_q;
  assign bus.carry = cout_q;

  // Datapath: sum_q/cout_q are only written on RUN->DONE so partial sums never show.
  always_comb begin
    lhs_sh_d = lhs_sh_q;
    rhs_sh_d = rhs_sh_q;
    acc_d    = acc_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    cnt_d    = cnt_q;
`ifdef SERIAL_ADD_SUB_EN
    sub_d    = sub_q;
`endif
    if (accept) begin
      lhs_sh_d = bus.lhs;
      rhs_sh_d = bus.rhs;
      carry_d  = carry_init;
      cnt_d    = '0;
`ifdef SERIAL_ADD_SUB_EN
      sub_d    = bus.sub;
`endif
    end else if (state_q == S_RUN) begin
      lhs_sh_d = lhs_sh_q >> 1;
      rhs_sh_d = rhs_sh_q >> 1;
      acc_d    = acc_shift;
      carry_d  = carry_next;
      cnt_d    = cnt_q + CW'(1);
      if (last) begin
        sum_d  = acc_shift;
        cout_d = carry_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lhs_sh_q <= '0;
      rhs_sh_q <= '0;
      acc_q    <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
`ifdef SERIAL_ADD_SUB_EN
      sub_q    <= 1'b0;
`endif
    end else begin
      lhs_sh_q <= lhs_sh_d;
      rhs_sh_q <= rhs_sh_d;
      acc_q    <= acc_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      cnt_q    <= cnt_d;
`ifdef SERIAL_ADD_SUB_EN
      sub_q    <= sub_d;
`endif
    end
  end
endmodule

// File: tb/tb_serial_add_controller.sv
// Directed + random bench for serial_add_controller (WIDTH=8) against an arithmetic reference.
module tb_serial_add_controller;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] prev_sum = '0;
  logic         prev_carry = 1'b0;

  always #5 clk = ~clk;

  serial_add_controller_if #(.WIDTH(W)) bus ();

  serial_add_controller #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, result is {carry, sum}.
  function automatic logic [W:0] model(input logic [W-1:0] l, input logic [W-1:0] r, input logic s);
    logic [W:0] res;
    if (s) begin
      res[W-1:0] = l - r;
      res[W]     = (l >= r);
    end else begin
      res = {1'b0, l} + {1'b0, r};
    end
    return res;
  endfunction

  task automatic set_sub(input logic s);
`ifdef SERIAL_ADD_SUB_EN
    bus.sub = s;
`else
    if (s) $display("note: sub requested but SERIAL_ADD_SUB_EN undefined");
`endif
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_busy"},      32'(bus.busy),      32'd0);
    chk({tag, "_sum"},       32'(bus.sum),       32'd0);
    chk({tag, "_carry"},     32'(bus.carry),     32'd0);
  endtask

  // Called at posedge+1 with DUT in IDLE; returns at posedge+1 with DUT back in IDLE.
  task automatic run_op(input string tag, input logic [W-1:0] l, input logic [W-1:0] r,
                        input logic s, input int hold, input logic inject);
    logic [W:0] exp;
    exp = model(l, r, s);
    bus.in_valid = 1'b1; bus.lhs = l; bus.rhs = r; set_sub(s);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.lhs = $urandom; bus.rhs = $urandom;
    chk({tag, "_busy0"},     32'(bus.busy),     32'd1);
    chk({tag, "_in_ready0"}, 32'(bus.in_ready), 32'd0);
    for (int i = 1; i < W; i++) begin
      if (inject && i == 2) begin bus.in_valid = 1'b1; bus.lhs = 8'h11; end
      @(posedge clk); #1;
      chk({tag, "_run_busy"},  32'(bus.busy),      32'd1);
      chk({tag, "_run_ov"},    32'(bus.out_valid), 32'd0);
      chk({tag, "_run_hold"},  32'({bus.carry, bus.sum}), 32'({prev_carry, prev_sum}));
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_done_busy"}, 32'(bus.busy),      32'd0);
    chk({tag, "_sum"},       32'(bus.sum),       32'(exp[W-1:0]));
    chk({tag, "_carry"},     32'(bus.carry),     32'(exp[W]));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_ov"},  32'(bus.out_valid), 32'd1);
      chk({tag, "_hold_sum"}, 32'({bus.carry, bus.sum}), 32'(exp));
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, "_ret_ov"},    32'(bus.out_valid), 32'd0);
    chk({tag, "_ret_ready"}, 32'(bus.in_ready),  32'd1);
    chk({tag, "_ret_sum"},   32'({bus.carry, bus.sum}), 32'(exp));
    prev_sum = exp[W-1:0]; prev_carry = exp[W];
  endtask

  initial begin
    logic [W:0] e1, e2;
    logic [W-1:0] rl, rr;
    logic rs;
    bus.in_valid = 1'b0; bus.lhs = '0; bus.rhs = '0; bus.out_ready = 1'b0; set_sub(1'b0);

    // Reset held 3 cycles
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst_hold");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals("rst_rel");

    // Basic add with backpressure, then overflow and zero cases
    run_op("basic", 8'h5A, 8'h33, 1'b0, 5, 1'b0);
    run_op("ovf",   8'hFF, 8'h01, 1'b0, 0, 1'b0);
    run_op("zero",  8'h00, 8'h00, 1'b0, 1, 1'b0);
    run_op("ignore", 8'h3C, 8'h4B, 1'b0, 0, 1'b1);

    // Throughput: in_valid and out_ready both held high
    e1 = model(8'h01, 8'h02, 1'b0);
    e2 = model(8'h80, 8'h80, 1'b0);
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.lhs = 8'h01; bus.rhs = 8'h02;
    @(posedge clk); #1;
    bus.lhs = 8'h80; bus.rhs = 8'h80;
    repeat (W) @(posedge clk);
    #1;
    chk("tp_ov1",  32'(bus.out_valid), 32'd1);
    chk("tp_res1", 32'({bus.carry, bus.sum}), 32'(e1));
    @(posedge clk); #1;
    chk("tp_idle", 32'(bus.in_ready), 32'd1);
    chk("tp_ov1_drop", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    chk("tp_accept2", 32'(bus.busy), 32'd1);
    bus.in_valid = 1'b0;
    repeat (W) @(posedge clk);
    #1;
    chk("tp_ov2",  32'(bus.out_valid), 32'd1);
    chk("tp_res2", 32'({bus.carry, bus.sum}), 32'(e2));
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("tp_end_idle", 32'(bus.in_ready), 32'd1);
    prev_sum = e2[W-1:0]; prev_carry = e2[W];

`ifdef SERIAL_ADD_SUB_EN
    run_op("sub_a", 8'h10, 8'h01, 1'b1, 0, 1'b0);
    run_op("sub_b", 8'h01, 8'h02, 1'b1, 0, 1'b0);
    run_op("sub_c", 8'h10, 8'h01, 1'b0, 0, 1'b0);
`endif

    // Random operands against the reference
    for (int n = 0; n < 20; n++) begin
      rl = W'($urandom);
      rr = W'($urandom);
`ifdef SERIAL_ADD_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      run_op("rand", rl, rr, rs, int'($urandom_range(0, 2)), 1'b0);
    end

    // Async reset mid-RUN, after a nonzero result is on the outputs
    run_op("pre_rst", 8'h5A, 8'h33, 1'b0, 0, 1'b0);
    bus.in_valid = 1'b1; bus.lhs = 8'h77; bus.rhs = 8'h22;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_async");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals("rst_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_add_controller.md
Name: serial_add_controller

Overview:
- Sequences a single 1-bit full-adder slice, built from two OneBitHalfAdder cells plus an OR, over WIDTH cycles to add two WIDTH-bit operands LSB-first.
- Sits between an operand producer and a result consumer, with a valid/ready handshake on each side.
- Trades area for latency: one adder slice, shift registers, a carry flop and a bit counter.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range >= 1.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, operand pair offered.
- in_ready, output, 1, controller can accept operands (IDLE only).
- lhs, input, WIDTH, left operand, sampled on in_valid&&in_ready.
- rhs, input, WIDTH, right operand, sampled on in_valid&&in_ready.
- out_valid, output, 1, result available (DONE only).
- out_ready, input, 1, consumer takes result.
- sum, output, WIDTH, result bits.
- carry, output, 1, carry-out of the MSB.
- busy, output, 1, high in RUN.

Behaviour:
- Reset: clk and rst_n only; async active-low; asserts immediately, releases synchronously to clk.
  - During reset: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, carry=0, counter=0, internal shift/carry regs=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready at an edge: load lhs/rhs into shift regs, carry_q=0, count=0, go to RUN.
  - RUN: busy=1, in_ready=0.
    - Each cycle the slice adds bit0 of both shift regs plus carry_q.
    - The sum bit shifts into the result reg from the MSB side; operands shift right; carry_q gets the new carry; count increments.
    - After WIDTH RUN cycles (count==WIDTH-1 at the edge), go to DONE.
  - DONE: out_valid=1; sum and carry are stable and held. On out_valid&&out_ready, go to IDLE.
- Slice datapath:
  - ha0(lhs_bit, rhs_bit) produces (s0, c0).
  - ha1(s0, carry_q) produces (sum_bit, c1).
  - carry_next = c0 | c1.
  - No other arithmetic in the datapath.
- Latency: out_valid rises WIDTH cycles after the accepting edge. Minimum initiation interval is WIDTH+2 cycles (one DONE cycle, one IDLE cycle).
- sum/carry in other states:
  - sum/carry hold the last completed result in IDLE and RUN.
  - The result reg updates only when transitioning RUN->DONE (shadowed), so sum never shows partial values.
- in_valid while not IDLE is ignored; operands are not queued.
- out_ready while not DONE is ignored.
- out_ready held high: DONE lasts exactly one cycle.
- WIDTH=1: one RUN cycle, then DONE.
- Wrap-around: a carry out of the MSB is reported on carry; sum is the modulo-2^WIDTH result.
- Reset mid-RUN or mid-DONE: in-flight operation discarded, all outputs return to reset values.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled with the operands.
  - When sub=1: the rhs bit is inverted before ha0 and carry_q is initialised to 1. The result is lhs-rhs modulo 2^WIDTH; carry=1 means no borrow (lhs>=rhs unsigned).
  - When sub=0: identical to add.
- Undefined: no sub port; add only; logic is identical to sub=0.

Test Plan (WIDTH=8):
- Reset: hold rst_n=0 for 3 cycles, release -> in_ready=1, out_valid=0, busy=0, sum=8'h00, carry=0. Then assert rst_n=0 asynchronously mid-RUN -> outputs return to these values without a clk edge.
- Basic add: lhs=8'h5A, rhs=8'h33 accepted at edge T -> busy high for 8 cycles, out_valid rises after edge T+8, sum=8'h8D, carry=0.
- Overflow: lhs=8'hFF, rhs=8'h01 -> sum=8'h00, carry=1; lhs=8'h00, rhs=8'h00 -> sum=8'h00, carry=0.
- Backpressure/ignore:
  - out_ready low for 5 cycles in DONE -> out_valid and sum=8'h8D held stable.
  - in_valid with lhs=8'h11 asserted during RUN -> not accepted; the next result is still from the original operands.
- Throughput: out_ready tied 1, in_valid tied 1 with two operand pairs (8'h01+8'h02, 8'h80+8'h80) -> results 8'h03/c0 then 8'h00/c1, accepting edges 10 cycles apart.
- SERIAL_ADD_SUB_EN:
  - sub=1, 8'h10-8'h01 -> sum=8'h0F, carry=1.
  - sub=1, 8'h01-8'h02 -> sum=8'hFF, carry=0.
  - sub=0, 8'h10+8'h01 -> sum=8'h11.
